// File: rtl/pipe_reg_elastic_pkg.sv
// Shared CPU pipeline types: per-boundary payload structs, the NOP bubble constant
// and the modulo-DEPTH pointer increment used by pipe_reg_elastic.
package pipe_reg_elastic_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          PTR_W     = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_pipeline_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } id_ex_pipeline_reg;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } ex_mem_pipeline_reg;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_pipeline_reg;

    // Wraps DEPTH-1 back to 0, so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned depth);
        return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH-entry valid/ready buffer with flush and a bubble on empty.
// Optional PIPE_REG_STATS_EN adds saturating stall_cnt/full_cnt outputs.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 2,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                full_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    // Handshake status comes only from registered count: no in_* -> out_* or out_ready -> in_ready path.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign occupancy = count;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= PW'(ptr_inc(PTR_W'(wr_ptr), DEPTH));
            if (pop)
                rd_ptr <= PW'(ptr_inc(PTR_W'(rd_ptr), DEPTH));
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is never reset; only the control state above is.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

`ifdef PIPE_REG_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            full_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if ((count == CW'(DEPTH)) && in_valid && (full_cnt != '1))
                full_cnt <= full_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: three instances (DEPTH 2, 3, 1) checked against a queue model.
// Stats checks are compiled in when PIPE_REG_STATS_EN is defined.
module tb_pipe_reg_elastic;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       flush, in_valid, out_ready, in_ready, out_valid;
    logic [2:0][31:0] in_data, out_data;
    logic [1:0]       occ_a, occ_b;
    logic [0:0]       occ_c;
`ifdef PIPE_REG_STATS_EN
    logic [2:0][31:0] stall_cnt, full_cnt;
`endif

    pipe_reg_elastic #(.DATA_W(32), .DEPTH(2), .BUBBLE(NOP)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .occupancy(occ_a)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt[0]), .full_cnt(full_cnt[0])
`endif
    );

    pipe_reg_elastic #(.DATA_W(32), .DEPTH(3), .BUBBLE(NOP)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .occupancy(occ_b)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt[1]), .full_cnt(full_cnt[1])
`endif
    );

    pipe_reg_elastic #(.DATA_W(32), .DEPTH(1), .BUBBLE(NOP)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .occupancy(occ_c)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt[2]), .full_cnt(full_cnt[2])
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: an ordered list per instance, oldest entry at index 0.
    logic [31:0] mdat [3][8];
    int          mcnt [3];
    int unsigned mstall [3];
    int unsigned mfull  [3];

    function automatic int dep(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int occ(input int k);
        case (k)
            0:       return int'(occ_a);
            1:       return int'(occ_b);
            default: return int'(occ_c);
        endcase
    endfunction

    function automatic logic [31:0] mhead(input int k);
        return (mcnt[k] > 0) ? mdat[k][0] : NOP;
    endfunction

    task automatic idle();
        in_valid  = '0;
        flush     = '0;
        out_ready = '0;
        in_data   = '0;
    endtask

    // One clock: derive push/pop from the model's occupancy, then apply them after the edge.
    task automatic tick();
        bit push [3];
        bit pop  [3];
        for (int k = 0; k < 3; k++) begin
            push[k] = in_valid[k] && (mcnt[k] < dep(k)) && !flush[k];
            pop[k]  = (mcnt[k] > 0) && out_ready[k] && !flush[k];
            if (rst) begin
                mstall[k] = 0;
                mfull[k]  = 0;
            end else begin
                if ((mcnt[k] > 0) && !out_ready[k] && !flush[k]) mstall[k]++;
                if ((mcnt[k] == dep(k)) && in_valid[k]) mfull[k]++;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst || flush[k]) begin
                mcnt[k] = 0;
            end else begin
                if (pop[k]) begin
                    for (int j = 0; j < 7; j++) mdat[k][j] = mdat[k][j+1];
                    mcnt[k]--;
                end
                if (push[k]) begin
                    mdat[k][mcnt[k]] = in_data[k];
                    mcnt[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (out_valid[k] !== 1'b0) begin
                    n_fail++; $display("FAIL reset_out_valid k=%0d c=%0d got %b want 0", k, c, out_valid[k]);
                end
                n_cmp++;
                if (out_data[k] !== NOP) begin
                    n_fail++; $display("FAIL reset_out_data k=%0d c=%0d got %h want %h", k, c, out_data[k], NOP);
                end
                n_cmp++;
                if (in_ready[k] !== 1'b1) begin
                    n_fail++; $display("FAIL reset_in_ready k=%0d c=%0d got %b want 1", k, c, in_ready[k]);
                end
                n_cmp++;
                if (occ(k) != 0) begin
                    n_fail++; $display("FAIL reset_occupancy k=%0d c=%0d got %0d want 0", k, c, occ(k));
                end
            end
            out_ready = '1;
            tick();
        end
        idle();
    endtask

    task automatic test_stream();
        idle();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'hA0 + i;
            n_cmp++;
            if (in_ready[0] !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready i=%0d got %b want 1", i, in_ready[0]);
            end
            tick();
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA0 + i) begin
                n_fail++; $display("FAIL stream_out i=%0d got v=%b d=%h want v=1 d=%h", i, out_valid[0], out_data[0], 32'hA0 + i);
            end
            n_cmp++;
            if (occ(0) != 1) begin
                n_fail++; $display("FAIL stream_occupancy i=%0d got %0d want 1", i, occ(0));
            end
        end
        in_valid[0] = 1'b0;
        tick();
        n_cmp++;
        if (occ(0) != 0 || out_data[0] !== NOP) begin
            n_fail++; $display("FAIL stream_drain got occ=%0d d=%h want occ=0 d=%h", occ(0), out_data[0], NOP);
        end
        idle();
    endtask

    task automatic test_full();
        idle();
        for (int i = 1; i <= 3; i++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = i;
            tick();
        end
        n_cmp++;
        if (occ(1) != 3 || in_ready[1] !== 1'b0) begin
            n_fail++; $display("FAIL full_state got occ=%0d rdy=%b want occ=3 rdy=0", occ(1), in_ready[1]);
        end
        in_data[1] = 32'h4;
        tick();
        n_cmp++;
        if (occ(1) != 3 || out_data[1] !== 32'h1) begin
            n_fail++; $display("FAIL full_reject got occ=%0d d=%h want occ=3 d=1", occ(1), out_data[1]);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_cmp++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== i) begin
                n_fail++; $display("FAIL full_drain i=%0d got v=%b d=%h want v=1 d=%h", i, out_valid[1], out_data[1], i);
            end
            tick();
        end
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 32'h4;
        tick();
        in_valid[1] = 1'b0;
        n_cmp++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 32'h4 || occ(1) != 1) begin
            n_fail++; $display("FAIL full_reoffer got v=%b d=%h occ=%0d want v=1 d=4 occ=1", out_valid[1], out_data[1], occ(1));
        end
        out_ready[1] = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_push_pop();
        idle();
        in_valid[0] = 1'b1;
        in_data[0]  = $urandom;
        tick();
        for (int i = 0; i < 20; i++) begin
            in_valid[0]  = 1'b1;
            out_ready[0] = 1'b1;
            in_data[0]   = $urandom;
            tick();
            n_cmp++;
            if (occ(0) != 1 || out_data[0] !== mhead(0)) begin
                n_fail++; $display("FAIL pushpop i=%0d got occ=%0d d=%h want occ=1 d=%h", i, occ(0), out_data[0], mhead(0));
            end
        end
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = 1'($urandom_range(1, 0));
                out_ready[k] = 1'($urandom_range(1, 0));
                flush[k]     = ($urandom_range(15, 0) == 0);
                in_data[k]   = $urandom;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (out_valid[k] !== (mcnt[k] > 0) || out_data[k] !== mhead(k) ||
                    in_ready[k] !== (mcnt[k] < dep(k)) || occ(k) != mcnt[k]) begin
                    n_fail++;
                    $display("FAIL random k=%0d i=%0d got v=%b d=%h r=%b occ=%0d want v=%b d=%h r=%b occ=%0d",
                             k, i, out_valid[k], out_data[k], in_ready[k], occ(k),
                             mcnt[k] > 0, mhead(k), mcnt[k] < dep(k), mcnt[k]);
                end
            end
        end
        idle();
        flush = '1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 2; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'h50 + i;
            tick();
        end
        n_cmp++;
        if (occ(0) != 2) begin
            n_fail++; $display("FAIL flush_prefill got occ=%0d want 2", occ(0));
        end
        flush[0]     = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hFF;
        out_ready[0] = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (occ(0) != 0 || out_valid[0] !== 1'b0 || out_data[0] !== NOP || in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL flush_after got occ=%0d v=%b d=%h r=%b want occ=0 v=0 d=%h r=1",
                               occ(0), out_valid[0], out_data[0], in_ready[0], NOP);
        end
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_data[0] === 32'hFF || out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL flush_dropped i=%0d got v=%b d=%h want v=0 d=%h", i, out_valid[0], out_data[0], NOP);
            end
        end
        idle();
    endtask

    task automatic test_depth1();
        int acc;
        idle();
        acc = 0;
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (in_ready[2] !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL d1_in_ready i=%0d got %b want %b", i, in_ready[2], (i % 2) == 0);
            end
            if ((i % 2) == 1) begin
                n_cmp++;
                if (out_valid[2] !== 1'b1 || out_data[2] !== 32'hC0 + acc - 1) begin
                    n_fail++; $display("FAIL d1_out i=%0d got v=%b d=%h want v=1 d=%h", i, out_valid[2], out_data[2], 32'hC0 + acc - 1);
                end
            end
            in_data[2] = 32'hC0 + acc;
            if (in_ready[2]) acc++;
            tick();
        end
        n_cmp++;
        if (acc != 5) begin
            n_fail++; $display("FAIL d1_rate got %0d transfers want 5", acc);
        end
        idle();
        tick();
    endtask

`ifdef PIPE_REG_STATS_EN
    task automatic test_stats();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (stall_cnt[2] !== 32'd0 || full_cnt[2] !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset got stall=%0d full=%0d want 0 0", stall_cnt[2], full_cnt[2]);
        end
        in_valid[2] = 1'b1;
        in_data[2]  = 32'h77;
        tick();
        tick();
        in_valid[2] = 1'b0;
        n_cmp++;
        if (full_cnt[2] !== 32'd1 || full_cnt[2] !== mfull[2]) begin
            n_fail++; $display("FAIL stats_full got %0d want 1", full_cnt[2]);
        end
        repeat (4) tick();
        n_cmp++;
        if (stall_cnt[2] !== 32'd5 || stall_cnt[2] !== mstall[2]) begin
            n_fail++; $display("FAIL stats_stall got %0d want 5", stall_cnt[2]);
        end
        flush[2] = 1'b1;
        tick();
        flush[2] = 1'b0;
        n_cmp++;
        if (stall_cnt[2] !== 32'd5 || occ(2) != 0) begin
            n_fail++; $display("FAIL stats_flush got stall=%0d occ=%0d want 5 0", stall_cnt[2], occ(2));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (stall_cnt[2] !== 32'd0 || full_cnt[2] !== 32'd0) begin
            n_fail++; $display("FAIL stats_rst got stall=%0d full=%0d want 0 0", stall_cnt[2], full_cnt[2]);
        end
        idle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        for (int k = 0; k < 3; k++) begin
            mcnt[k]   = 0;
            mstall[k] = 0;
            mfull[k]  = 0;
            for (int j = 0; j < 8; j++) mdat[k][j] = '0;
        end
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_push_pop();
        test_flush();
        test_depth1();
`ifdef PIPE_REG_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
